// File: rtl/graphpulse_pkg.sv
// Shared graphpulse definitions: memory bus commands and the tag-table entry
// used by the memory port arbiter.
//   BUS_NONE / BUS_LOAD / BUS_STORE : 2-bit memory command encoding
//   tag_entry_t                     : {valid, owning channel index}
package graphpulse_pkg;

  localparam int XLEN     = 32;
  // Wide enough for any practical channel count. The arbiter casts to its own
  // index width when it reads the field back.
  localparam int CH_IDX_W = 8;

  localparam logic [1:0] BUS_NONE  = 2'h0;
  localparam logic [1:0] BUS_LOAD  = 2'h1;
  localparam logic [1:0] BUS_STORE = 2'h2;

  typedef struct packed {
    logic                valid;
    logic [CH_IDX_W-1:0] ch;
  } tag_entry_t;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick. It returns the first requester at or after
// ptr, wrapping around.
//   req          in  N       request vector
//   ptr          in  log2 N  highest-priority index this cycle
//   grant_onehot out N       one-hot grant (all zero when any=0)
//   grant_idx    out log2 N  index of the grant (0 when any=0)
//   any          out 1       at least one request present
module rr_arbiter #(
  parameter int N = 4
) (
  input  logic [N-1:0]         req,
  input  logic [$clog2(N)-1:0] ptr,
  output logic [N-1:0]         grant_onehot,
  output logic [$clog2(N)-1:0] grant_idx,
  output logic                 any
);

  localparam int PW = $clog2(N);

  int idx;

  always_comb begin
    grant_onehot = '0;
    grant_idx    = '0;
    any          = 1'b0;
    idx          = 0;
    // Scan from the farthest offset down to offset 0. The last hit is the one
    // closest to ptr, so it wins.
    for (int k = N - 1; k >= 0; k--) begin
      idx = (int'(ptr) + k) % N;
      if (req[idx]) begin
        grant_idx = PW'(idx);
        any       = 1'b1;
      end
    end
    if (any) grant_onehot[grant_idx] = 1'b1;
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one tagged memory port among NUM_CH graphpulse channels.
// A round-robin grant drives the port. A tag table routes returning load data
// back to the channel that issued the load. Per-channel counters cap the
// number of outstanding loads for each channel.
//   clock, reset            system clock, synchronous active-high reset
//   ch_req_*                per-channel request (valid/cmd/addr/data), ready out
//   ch_resp_valid/data      one-hot load-data pulse, shared data bus
//   mem_command/addr/st_data  request toward memory
//   mem_response            nonzero = command accepted with this tag
//   mem_ld_data/mem_tag     returning load data and its tag
//   busy                    any load outstanding
//   err_unmatched           sticky protocol-error flag
//
// Handshake: a channel holds valid/cmd/addr/data stable until it sees ready.
// ready is a one-cycle pulse in the cycle memory accepts (mem_response != 0).
// ch_resp_valid is a one-cycle pulse with no backpressure; the channel must
// take the data in that cycle.
module mem_port_arbiter
  import graphpulse_pkg::*;
#(
  parameter int NUM_CH    = 4,
  parameter int ADDR_W    = XLEN,
  parameter int DATA_W    = 64,
  parameter int TAG_W     = 4,
  parameter int MAX_OUTST = 4
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic [NUM_CH-1:0]        ch_req_valid,
  input  logic [2*NUM_CH-1:0]      ch_req_cmd,
  input  logic [ADDR_W*NUM_CH-1:0] ch_req_addr,
  input  logic [DATA_W*NUM_CH-1:0] ch_req_data,
  output logic [NUM_CH-1:0]        ch_req_ready,
  output logic [NUM_CH-1:0]        ch_resp_valid,
  output logic [DATA_W-1:0]        ch_resp_data,
  output logic [1:0]               mem_command,
  output logic [ADDR_W-1:0]        mem_addr,
  output logic [DATA_W-1:0]        mem_st_data,
  input  logic [TAG_W-1:0]         mem_response,
  input  logic [DATA_W-1:0]        mem_ld_data,
  input  logic [TAG_W-1:0]         mem_tag,
  output logic                     busy,
  output logic                     err_unmatched
);

  localparam int CW = $clog2(NUM_CH);
  localparam int OW = $clog2(MAX_OUTST + 1);
  localparam int NT = 2 ** TAG_W;

  logic [CW-1:0] rr_ptr;
  tag_entry_t    tag_tbl [NT];
  logic [OW-1:0] outst   [NUM_CH];

  logic [NUM_CH-1:0] eligible;
  logic [NUM_CH-1:0] grant_onehot;
  logic [CW-1:0]     grant_idx;
  logic              grant_any;
  logic [1:0]        sel_cmd;
  logic              accept;
  logic              load_acc;
  tag_entry_t        hit_entry;
  logic              tag_seen;
  logic              resp_hit;
  logic [CW-1:0]     resp_ch;

  // While reset is high, nothing is eligible. That alone forces
  // mem_command=BUS_NONE and ready=0.
  always_comb begin
    eligible = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      eligible[i] = !reset && ch_req_valid[i] &&
                    (ch_req_cmd[2*i +: 2] == BUS_STORE || outst[i] < OW'(MAX_OUTST));
    end
  end

  rr_arbiter #(.N(NUM_CH)) u_rr (
    .req          (eligible),
    .ptr          (rr_ptr),
    .grant_onehot (grant_onehot),
    .grant_idx    (grant_idx),
    .any          (grant_any)
  );

  always_comb begin
    sel_cmd     = BUS_NONE;
    mem_addr    = '0;
    mem_st_data = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (grant_idx == CW'(i)) begin
        sel_cmd     = ch_req_cmd[2*i +: 2];
        mem_addr    = ch_req_addr[ADDR_W*i +: ADDR_W];
        mem_st_data = ch_req_data[DATA_W*i +: DATA_W];
      end
    end
  end

  assign mem_command  = grant_any ? sel_cmd : BUS_NONE;
  assign accept       = grant_any && (mem_response != '0);
  assign load_acc     = accept && (sel_cmd == BUS_LOAD);
  assign ch_req_ready = accept ? grant_onehot : '0;

  // Response routing is purely combinational from the current table contents.
  assign hit_entry    = tag_tbl[mem_tag];
  assign tag_seen     = !reset && (mem_tag != '0);
  assign resp_hit     = tag_seen && hit_entry.valid;
  assign resp_ch      = CW'(hit_entry.ch);
  assign ch_resp_data = mem_ld_data;

  always_comb begin
    ch_resp_valid = '0;
    if (resp_hit) ch_resp_valid[resp_ch] = 1'b1;
  end

  always_comb begin
    busy = 1'b0;
    for (int i = 0; i < NUM_CH; i++) busy = busy || (outst[i] != '0);
    busy = busy && !reset;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      rr_ptr        <= '0;
      err_unmatched <= 1'b0;
      for (int t = 0; t < NT; t++) tag_tbl[t] <= '0;
      for (int i = 0; i < NUM_CH; i++) outst[i] <= '0;
    end else begin
      if (accept) begin
        if (int'(grant_idx) == NUM_CH - 1) rr_ptr <= '0;
        else                               rr_ptr <= grant_idx + 1'b1;
      end
      // Retire first, then allocate. If both touch the same tag, the
      // allocation wins because it is the later assignment.
      if (resp_hit) tag_tbl[mem_tag].valid <= 1'b0;
      if (load_acc) begin
        tag_tbl[mem_response].valid <= 1'b1;
        tag_tbl[mem_response].ch    <= CH_IDX_W'(grant_idx);
      end
      if (tag_seen && !hit_entry.valid) err_unmatched <= 1'b1;
      // Allocating onto a live tag is an error unless that same tag is being
      // retired in this cycle.
      if (load_acc && tag_tbl[mem_response].valid &&
          !(resp_hit && mem_tag == mem_response))
        err_unmatched <= 1'b1;
      for (int i = 0; i < NUM_CH; i++) begin
        if ((load_acc && grant_idx == CW'(i)) && !(resp_hit && resp_ch == CW'(i)))
          outst[i] <= outst[i] + 1'b1;
        else if (!(load_acc && grant_idx == CW'(i)) && (resp_hit && resp_ch == CW'(i)))
          outst[i] <= outst[i] - 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter with 4 channels and MAX_OUTST=2.
module tb_mem_port_arbiter;
  import graphpulse_pkg::*;

  localparam int NUM_CH = 4;
  localparam int ADDR_W = 32;
  localparam int DATA_W = 64;
  localparam int TAG_W  = 4;
  localparam int MAXO   = 2;

  logic                     clock = 1'b0;
  logic                     reset;
  logic [NUM_CH-1:0]        ch_req_valid;
  logic [2*NUM_CH-1:0]      ch_req_cmd;
  logic [ADDR_W*NUM_CH-1:0] ch_req_addr;
  logic [DATA_W*NUM_CH-1:0] ch_req_data;
  logic [NUM_CH-1:0]        ch_req_ready;
  logic [NUM_CH-1:0]        ch_resp_valid;
  logic [DATA_W-1:0]        ch_resp_data;
  logic [1:0]               mem_command;
  logic [ADDR_W-1:0]        mem_addr;
  logic [DATA_W-1:0]        mem_st_data;
  logic [TAG_W-1:0]         mem_response;
  logic [DATA_W-1:0]        mem_ld_data;
  logic [TAG_W-1:0]         mem_tag;
  logic                     busy;
  logic                     err_unmatched;

  int checks = 0;
  int errors = 0;
  logic [NUM_CH-1:0] exp_q[$];

  mem_port_arbiter #(
    .NUM_CH(NUM_CH), .ADDR_W(ADDR_W), .DATA_W(DATA_W), .TAG_W(TAG_W), .MAX_OUTST(MAXO)
  ) dut (
    .clock(clock), .reset(reset),
    .ch_req_valid(ch_req_valid), .ch_req_cmd(ch_req_cmd),
    .ch_req_addr(ch_req_addr), .ch_req_data(ch_req_data),
    .ch_req_ready(ch_req_ready), .ch_resp_valid(ch_resp_valid),
    .ch_resp_data(ch_resp_data), .mem_command(mem_command),
    .mem_addr(mem_addr), .mem_st_data(mem_st_data),
    .mem_response(mem_response), .mem_ld_data(mem_ld_data),
    .mem_tag(mem_tag), .busy(busy), .err_unmatched(err_unmatched)
  );

  // clock / reset
  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic reset_pulse();
    reset = 1'b1;
    tick();
    reset = 1'b0;
  endtask

  // drivers
  task automatic set_ch(input int i, input logic v, input logic [1:0] c,
                        input logic [31:0] a, input logic [63:0] d);
    ch_req_valid[i]           = v;
    ch_req_cmd[2*i +: 2]      = c;
    ch_req_addr[32*i +: 32]   = a;
    ch_req_data[64*i +: 64]   = d;
  endtask

  task automatic idle_all();
    ch_req_valid = '0;
    ch_req_cmd   = '0;
    ch_req_addr  = '0;
    ch_req_data  = '0;
    mem_response = '0;
    mem_tag      = '0;
    mem_ld_data  = '0;
  endtask

  // checker
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    logic [NUM_CH-1:0] e;
    idle_all();
    reset = 1'b1;

    // Reset: outputs are quiet even with a live request and a response present.
    set_ch(0, 1'b1, BUS_LOAD, 32'h100, 64'h0);
    mem_response = 4'd3;
    #1;
    chk("rst_cmd",   64'(mem_command),   64'(BUS_NONE));
    chk("rst_ready", 64'(ch_req_ready),  64'h0);
    chk("rst_rv",    64'(ch_resp_valid), 64'h0);
    chk("rst_busy",  64'(busy),          64'h0);
    tick();
    tick();
    chk("rst_err",   64'(err_unmatched), 64'h0);
    reset = 1'b0;

    // 1: single load, then its response.
    #1;
    chk("t1_ready", 64'(ch_req_ready), 64'h1);
    chk("t1_cmd",   64'(mem_command),  64'(BUS_LOAD));
    chk("t1_addr",  64'(mem_addr),     64'h100);
    tick();
    idle_all();
    #1;
    chk("t1_busy", 64'(busy), 64'h1);
    mem_tag = 4'd3; mem_ld_data = 64'hDEAD;
    #1;
    chk("t1_rv",    64'(ch_resp_valid), 64'h1);
    chk("t1_rdata", ch_resp_data,       64'hDEAD);
    tick();
    idle_all();
    #1;
    chk("t1_busy0", 64'(busy), 64'h0);

    // 2: four stores, every cycle accepted, rotating grant.
    reset_pulse();
    for (int i = 0; i < NUM_CH; i++) set_ch(i, 1'b1, BUS_STORE, 32'h400 + 32'(i), 64'(i));
    mem_response = 4'd1;
    exp_q.push_back(4'b0001); exp_q.push_back(4'b0010); exp_q.push_back(4'b0100);
    exp_q.push_back(4'b1000); exp_q.push_back(4'b0001);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      #1;
      chk("t2_grant", 64'(ch_req_ready), 64'(e));
      chk("t2_cmd",   64'(mem_command),  64'(BUS_STORE));
      tick();
    end
    chk("t2_busy", 64'(busy), 64'h0);
    idle_all();

    // 3: ch2 store held for three refused cycles, then accepted on tag 5.
    set_ch(2, 1'b1, BUS_STORE, 32'h200, 64'h1234);
    for (int c = 0; c < 3; c++) begin
      #1;
      chk("t3_addr",  64'(mem_addr),     64'h200);
      chk("t3_data",  mem_st_data,       64'h1234);
      chk("t3_ready", 64'(ch_req_ready), 64'h0);
      tick();
    end
    mem_response = 4'd5;
    #1;
    chk("t3_addr4",  64'(mem_addr),     64'h200);
    chk("t3_ready4", 64'(ch_req_ready), 64'h4);
    tick();
    idle_all();
    chk("t3_busy", 64'(busy), 64'h0);
    mem_tag = 4'd5;
    #1;
    chk("t3_no_entry", 64'(ch_resp_valid), 64'h0);
    tick();
    mem_tag = '0;
    chk("t3_err", 64'(err_unmatched), 64'h1);

    // 4: outstanding limit on ch1.
    reset_pulse();
    set_ch(1, 1'b1, BUS_LOAD, 32'h300, 64'h0);
    mem_response = 4'd1;
    #1;
    chk("t4_ld1", 64'(ch_req_ready), 64'h2);
    tick();
    set_ch(1, 1'b1, BUS_LOAD, 32'h308, 64'h0);
    mem_response = 4'd2;
    #1;
    chk("t4_ld2", 64'(ch_req_ready), 64'h2);
    tick();
    set_ch(1, 1'b1, BUS_LOAD, 32'h310, 64'h0);
    mem_response = 4'd0;
    #1;
    chk("t4_inelig_cmd", 64'(mem_command), 64'(BUS_NONE));
    set_ch(3, 1'b1, BUS_LOAD, 32'h330, 64'h0);
    mem_response = 4'd6;
    #1;
    chk("t4_ch3", 64'(ch_req_ready), 64'h8);
    tick();
    set_ch(3, 1'b0, BUS_NONE, 32'h0, 64'h0);
    mem_response = 4'd0;
    mem_tag = 4'd1; mem_ld_data = 64'hAAAA;
    #1;
    chk("t4_resp",     64'(ch_resp_valid), 64'h2);
    chk("t4_resp_cmd", 64'(mem_command),   64'(BUS_NONE));
    tick();
    mem_tag = '0;
    mem_response = 4'd7;
    #1;
    chk("t4_regrant", 64'(ch_req_ready), 64'h2);
    tick();
    idle_all();
    chk("t4_busy", 64'(busy), 64'h1);

    // 5: unmatched tag sets the sticky error.
    reset_pulse();
    chk("t5_err0", 64'(err_unmatched), 64'h0);
    mem_tag = 4'd7;
    #1;
    chk("t5_rv", 64'(ch_resp_valid), 64'h0);
    tick();
    mem_tag = '0;
    tick();
    tick();
    chk("t5_err_hold", 64'(err_unmatched), 64'h1);
    reset_pulse();
    chk("t5_err_clr", 64'(err_unmatched), 64'h0);

    // 6: tag 4 retires for ch0 while being reallocated to ch2.
    set_ch(0, 1'b1, BUS_LOAD, 32'h500, 64'h0);
    mem_response = 4'd4;
    #1;
    chk("t6_ld0", 64'(ch_req_ready), 64'h1);
    tick();
    set_ch(0, 1'b0, BUS_NONE, 32'h0, 64'h0);
    set_ch(2, 1'b1, BUS_LOAD, 32'h520, 64'h0);
    mem_tag = 4'd4; mem_ld_data = 64'hBEEF;
    #1;
    chk("t6_ld2",   64'(ch_req_ready),  64'h4);
    chk("t6_rv0",   64'(ch_resp_valid), 64'h1);
    chk("t6_data0", ch_resp_data,       64'hBEEF);
    tick();
    idle_all();
    chk("t6_err0", 64'(err_unmatched), 64'h0);
    mem_tag = 4'd4; mem_ld_data = 64'hCAFE;
    #1;
    chk("t6_rv2",   64'(ch_resp_valid), 64'h4);
    chk("t6_data2", ch_resp_data,       64'hCAFE);
    tick();
    idle_all();
    chk("t6_busy0", 64'(busy), 64'h0);

    // Allocation onto a still-live tag.
    set_ch(0, 1'b1, BUS_LOAD, 32'h600, 64'h0);
    mem_response = 4'd10;
    tick();
    tick();
    idle_all();
    chk("t6_dup_err", 64'(err_unmatched), 64'h1);
    reset_pulse();

    // Reset with two loads outstanding, then a late response.
    set_ch(0, 1'b1, BUS_LOAD, 32'h700, 64'h0);
    mem_response = 4'd8;
    tick();
    set_ch(0, 1'b0, BUS_NONE, 32'h0, 64'h0);
    set_ch(1, 1'b1, BUS_LOAD, 32'h710, 64'h0);
    mem_response = 4'd9;
    tick();
    idle_all();
    chk("t6_busy2", 64'(busy), 64'h1);
    reset = 1'b1;
    #1;
    chk("t6_busy_rst", 64'(busy), 64'h0);
    tick();
    reset = 1'b0;
    mem_tag = 4'd8;
    #1;
    chk("t6_late_rv", 64'(ch_resp_valid), 64'h0);
    tick();
    mem_tag = '0;
    chk("t6_late_err", 64'(err_unmatched), 64'h1);

    // report
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
